cond_route_stage: RTL

//  Upstream stage that classifies each input word into one of three priority branches.

---
 rtl/cond_route_pkg.sv | 43 ++++
 rtl/cond_route_skid.sv | 70 +++++++
 rtl/cond_route_stage.sv | 81 ++++++++
 3 files changed

// File: rtl/cond_route_pkg.sv
// Shared types and helpers for the conditional routing stage.
// Branch encoding, priority classification and one-hot decode live here so
// the stage top level and the bench agree on a single definition.
package cond_route_pkg;

  localparam int NUM_BR = 3;
  localparam int BR_W   = 2;

  typedef enum logic [1:0] {
    BR_IF   = 2'd0,
    BR_ELIF = 2'd1,
    BR_ELSE = 2'd2
  } branch_e;

  // Skid buffer occupancy.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // cond_a wins outright; cond_b only matters when cond_a is low.
  function automatic branch_e classify(input logic a, input logic b);
    if (a) begin
      return BR_IF;
    end
    if (b) begin
      return BR_ELIF;
    end
    return BR_ELSE;
  endfunction

  // One-hot select in {ELSE,ELIF,IF} bit order.
  function automatic logic [2:0] onehot(input branch_e br);
    case (br)
      BR_IF:   return 3'b001;
      BR_ELIF: return 3'b010;
      BR_ELSE: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/cond_route_skid.sv
// Two-entry valid/ready skid buffer with a fully registered in_ready.
// The head register drives the output directly; the skid register catches
// the word that arrives in the cycle downstream stalls.
module cond_route_skid
  import cond_route_pkg::*;
#(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  occ_e         occ;
  occ_e         occ_nxt;
  logic [W-1:0] head;
  logic [W-1:0] skid;
  logic         push;
  logic         pop;

  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_valid = (occ != OCC_EMPTY);
  assign out_data  = head;

  // Next occupancy from the push/pop pair.
  always_comb begin
    // NOTE: default assignment first so no path leaves occ_nxt unassigned (no latch).
    occ_nxt = occ;
    case (occ)
      OCC_EMPTY: if (push) occ_nxt = OCC_ONE;
      OCC_ONE: begin
        if (push && !pop)      occ_nxt = OCC_FULL;
        else if (pop && !push) occ_nxt = OCC_EMPTY;
      end
      OCC_FULL:  if (pop) occ_nxt = OCC_ONE;
      default:   occ_nxt = OCC_EMPTY;
    endcase
  end

  // State, registered in_ready and the two storage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ      <= OCC_EMPTY;
      in_ready <= 1'b1;
      // NOTE: only two words of storage, and out_data must read 0 after reset, so both are reset.
      head     <= '0;
      skid     <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      occ      <= occ_nxt;
      in_ready <= (occ_nxt != OCC_FULL);
      case (occ)
        OCC_EMPTY: if (push) head <= in_data;
        OCC_ONE: begin
          if (push && pop) head <= in_data;
          else if (push)   skid <= in_data;
        end
        OCC_FULL:  if (pop) head <= skid;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cond_route_stage.sv
// Conditional routing stage: classifies each word into IF / ELIF / ELSE by
// priority, stores the branch alongside the word in a 2-entry skid buffer and
// presents the word with a one-hot branch select downstream.
// Optional per-branch saturating statistics counters are built when the macro
// COND_ROUTE_STATS_EN is defined; otherwise stat_clr/stat_cnt do not exist.
module cond_route_stage
  import cond_route_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_cond_a,
  input  logic              in_cond_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        out_sel
`ifdef COND_ROUTE_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [3*CNT_W-1:0] stat_cnt
`endif
);

  localparam int PW = DATA_W + BR_W;

  branch_e       in_br;
  branch_e       out_br;
  logic [PW-1:0] in_word;
  logic [PW-1:0] out_word;

  // Branch is decided on the way in; it only reaches storage on a push, so
  // undefined conditions on idle cycles never land in the buffer.
  assign in_br   = classify(in_cond_a, in_cond_b);
  assign in_word = {in_br, in_data};

  cond_route_skid #(
    .W (PW)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_word)
  );

  assign out_br   = branch_e'(out_word[DATA_W +: BR_W]);
  assign out_data = out_word[DATA_W-1:0];
  assign out_sel  = out_valid ? onehot(out_br) : 3'b000;

`ifdef COND_ROUTE_STATS_EN
  logic [CNT_W-1:0] cnt [NUM_BR];
  logic             out_hs;

  assign out_hs = out_valid && out_ready;

  // Per-branch saturating handshake counters; clear beats increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BR; i++) cnt[i] <= '0;
    end else if (stat_clr) begin
      for (int i = 0; i < NUM_BR; i++) cnt[i] <= '0;
    end else if (out_hs) begin
      for (int i = 0; i < NUM_BR; i++) begin
        if (out_sel[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  assign stat_cnt = {cnt[2], cnt[1], cnt[0]};
`endif

endmodule
